// File: rtl/ntt_pkg.sv
// Constants and the row-to-bank rotation shared by the loader and the NTT core address path.
package ntt_pkg;
  localparam int N    = 2048;
  localparam int ROWW = 9;
  localparam int IN_W = 16;
  localparam int DW   = 14;
  localparam int Q    = 12289;
  localparam int CW   = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  // Sum of the base-4 digits of the row address, mod 4.
  function automatic logic [1:0] bank_sel(input logic [ROWW-1:0] row);
    logic [ROWW+1:0] r;
    logic [1:0]      acc;
    r   = {2'b00, row};
    acc = '0;
    for (int i = 0; i < ROWW; i += 2) acc = acc + r[i +: 2];
    return acc;
  endfunction
endpackage

// File: rtl/mod_reduce_q.sv
// One registered stage: unsigned IN_W input reduced into [0, Q-1].
// hold_i freezes both the valid flag and the stored result.
module mod_reduce_q
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            hold_i,
  input  logic            vld_i,
  input  logic [IN_W-1:0] dat_i,
  output logic            vld_o,
  output logic [DW-1:0]   dat_o
);
  logic            vld_q;
  logic [DW-1:0]   dat_q;
  logic [DW-1:0]   dat_d;
  logic [IN_W-1:0] sub;

  // The 16-bit input range never exceeds a quotient of 5.
  always_comb begin
    sub = dat_i;
    if      (dat_i >= IN_W'(5 * Q)) sub = dat_i - IN_W'(5 * Q);
    else if (dat_i >= IN_W'(4 * Q)) sub = dat_i - IN_W'(4 * Q);
    else if (dat_i >= IN_W'(3 * Q)) sub = dat_i - IN_W'(3 * Q);
    else if (dat_i >= IN_W'(2 * Q)) sub = dat_i - IN_W'(2 * Q);
    else if (dat_i >= IN_W'(Q))     sub = dat_i - IN_W'(Q);
    dat_d = sub[DW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (!hold_i) begin
      vld_q <= vld_i;
      if (vld_i) dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

// File: rtl/ntt_loader.sv
// Streams N coefficients, reduces them mod Q and writes rows of four into the rotated banks.
// Handshake of the row's last coefficient to wr_en is 2 cycles; ntt_busy freezes the whole pipe.
module ntt_loader
  import ntt_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            ntt_busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            wr_en,
  output logic [ROWW-1:0] wr_row,
  output logic [DW-1:0]   wr_data0,
  output logic [DW-1:0]   wr_data1,
  output logic [DW-1:0]   wr_data2,
  output logic [DW-1:0]   wr_data3,
  output logic            busy,
  output logic            done
);
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   col_q;
  logic            busy_q, done_q;
  logic [DW-1:0]   buf_q      [3];
  logic            pend_q;
  logic [ROWW-1:0] pend_row_q;
  logic [DW-1:0]   pend_dat_q [4];
  logic [DW-1:0]   pend_dat_d [4];
  logic [DW-1:0]   row_lanes  [4];

  logic            red_vld;
  logic [DW-1:0]   red_dat;
  logic            hs, stall, row_wr, consume, start_ok;
  logic [1:0]      lane, rot, idx;
  logic [ROWW-1:0] row;

  assign row_wr   = pend_q && !ntt_busy;
  assign stall    = ntt_busy || (pend_q && !row_wr);
  assign in_ready = (state_q == S_LOAD) && (cnt_q < CW'(N)) && !stall;
  assign hs       = in_valid && in_ready;
  assign start_ok = (state_q == S_IDLE) && start && !ntt_busy;
  assign consume  = red_vld && !ntt_busy;
  assign lane     = col_q[1:0];
  assign row      = col_q[ROWW+1:2];
  assign rot      = bank_sel(row);

  mod_reduce_q u_red (
    .clk    (clk),
    .rstn   (rstn),
    .hold_i (ntt_busy),
    .vld_i  (hs),
    .dat_i  (in_data),
    .vld_o  (red_vld),
    .dat_o  (red_dat)
  );

  // Bank b takes lane (b - rot) mod 4; lane 3 arrives straight from the reducer.
  always_comb begin
    for (int i = 0; i < 3; i++) row_lanes[i] = buf_q[i];
    row_lanes[3] = red_dat;
    idx = '0;
    for (int b = 0; b < 4; b++) begin
      idx           = 2'(b) - rot;
      pend_dat_d[b] = row_lanes[idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok) begin
          state_q <= S_LOAD;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        S_LOAD: if (hs) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= S_FLUSH;
        end
        S_FLUSH: if (row_wr && pend_row_q == ROWW'(N / 4 - 1)) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q      <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      for (int b = 0; b < 4; b++) pend_dat_q[b] <= '0;
    end else begin
      if (start_ok)     col_q <= '0;
      else if (consume) col_q <= col_q + 1'b1;
      for (int i = 0; i < 3; i++)
        if (consume && lane == 2'(i)) buf_q[i] <= red_dat;
      // A written row frees the holding register in the same cycle a new one can land.
      if (consume && lane == 2'd3) begin
        pend_q     <= 1'b1;
        pend_row_q <= row;
        for (int b = 0; b < 4; b++) pend_dat_q[b] <= pend_dat_d[b];
      end else if (row_wr) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign wr_en    = row_wr;
  assign wr_row   = pend_row_q;
  assign wr_data0 = pend_dat_q[0];
  assign wr_data1 = pend_dat_q[1];
  assign wr_data2 = pend_dat_q[2];
  assign wr_data3 = pend_dat_q[3];
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_ntt_loader.sv
// Directed bench for ntt_loader with a row scoreboard filled by the input driver.
module tb_ntt_loader;
  localparam int TN = 2048;
  localparam int TQ = 12289;

  logic        clk = 1'b0;
  logic        rstn, start, ntt_busy, in_valid, in_ready;
  logic [15:0] in_data;
  logic        wr_en, busy, done;
  logic [8:0]  wr_row;
  logic [13:0] wr_data0, wr_data1, wr_data2, wr_data3;

  ntt_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .ntt_busy(ntt_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_row(wr_row),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [8:0]  row;
    logic [13:0] d3, d2, d1, d0;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [13:0] lane_v [4];
  logic [13:0] cap [512][4];
  int          mode, wr_cnt, done_cnt, last_wr_cyc, last_wr_row, row0_cyc, hs3_cyc, first_row;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int raw_val(input int n);
    if (mode == 1) begin
      case (n)
        100: return 65535;
        101: return 12289;
        102: return 12288;
        103: return 24578;
        104: return 0;
        default: return n;
      endcase
    end
    if (mode == 2) return (n * 37 + 11) % 65536;
    return n;
  endfunction

  function automatic int rot_of(input int row);
    int r, s;
    r = row;
    s = 0;
    while (r > 0) begin
      s += r % 4;
      r /= 4;
    end
    return s % 4;
  endfunction

  always @(negedge clk) begin
    wr_t e, o;
    if (rstn && wr_en) begin
      o = {wr_row, wr_data3, wr_data2, wr_data1, wr_data0};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_extra observed row=%0d expected no write", wr_row);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_row_data", 80'(o), 80'(e));
      end
      cap[wr_row][0] = wr_data0;
      cap[wr_row][1] = wr_data1;
      cap[wr_row][2] = wr_data2;
      cap[wr_row][3] = wr_data3;
      if (first_row < 0) first_row = int'(wr_row);
      if (wr_row == 0) row0_cyc = cyc;
      wr_cnt++;
      last_wr_cyc = cyc;
      last_wr_row = int'(wr_row);
    end
    if (rstn && done) begin
      chk("done_after_last_row", {cyc - last_wr_cyc, last_wr_row}, {32'd1, 32'd511});
      done_cnt++;
    end
  end

  task automatic drive_one(input int n, input bit gaps);
    int k, raw;
    wr_t e;
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(posedge clk); #1;
      end
    raw      = raw_val(n);
    in_valid = 1'b1;
    in_data  = 16'(raw);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    checks++;
    assert (k < 200) else begin
      errors++;
      $error("FAIL hs_timeout coef=%0d observed no in_ready expected handshake", n);
    end
    if (k < 200) begin
      if (n == 3) hs3_cyc = cyc;
      lane_v[n % 4] = 14'(raw % TQ);
      if (n % 4 == 3) begin
        e.row = 9'(n / 4);
        e.d0  = lane_v[(0 - rot_of(n / 4) + 4) % 4];
        e.d1  = lane_v[(1 - rot_of(n / 4) + 4) % 4];
        e.d2  = lane_v[(2 - rot_of(n / 4) + 4) % 4];
        e.d3  = lane_v[(3 - rot_of(n / 4) + 4) % 4];
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input int first, input int last, input bit gaps);
    for (int n = first; n <= last; n++) drive_one(n, gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int prev, k;
    prev = done_cnt;
    for (k = 0; k < 6000; k++) begin
      @(posedge clk);
      if (done_cnt > prev) break;
    end
    #1;
    chk("done_seen", 80'(done_cnt > prev), 80'(1));
  endtask

  initial begin
    rstn = 1'b1; start = 1'b0; ntt_busy = 1'b0; in_valid = 1'b0; in_data = '0;
    mode = 0; wr_cnt = 0; done_cnt = 0; first_row = -1;
    #1 rstn = 1'b0;
    #11;
    chk("rst_outputs", {in_ready, wr_en, busy, done, wr_row}, '0);
    chk("rst_data", {wr_data0, wr_data1, wr_data2, wr_data3}, '0);
    @(posedge clk); #1 rstn = 1'b1;

    // Idle: valid data and a start blocked by ntt_busy are both ignored.
    in_valid = 1'b1; in_data = 16'd123;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", 80'(in_ready), 80'(0));
    #4 in_valid = 1'b0;
    ntt_busy = 1'b1;
    pulse_start();
    ntt_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("start_while_ntt_busy", {busy, in_ready}, '0);
    @(posedge clk); #1;

    // Frame 1: contiguous stream of 0..N-1.
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", {busy, in_ready}, {1'b1, 1'b1});
    @(posedge clk); #1;
    send(0, TN - 1, 1'b0);
    wait_done();
    chk("f1_wr_count", 80'(wr_cnt), 80'(512));
    chk("f1_latency", 80'(row0_cyc - hs3_cyc), 80'(2));
    chk("f1_row0", {cap[0][0], cap[0][1], cap[0][2], cap[0][3]}, {14'd0, 14'd1, 14'd2, 14'd3});
    chk("f1_row1", {cap[1][0], cap[1][1], cap[1][2], cap[1][3]}, {14'd7, 14'd4, 14'd5, 14'd6});
    chk("f1_idle_after", {busy, done}, '0);

    // Frame 2: same data with random valid gaps.
    wr_cnt = 0;
    cap[1][0] = '0;
    pulse_start();
    send(0, TN - 1, 1'b1);
    wait_done();
    chk("f2_wr_count", 80'(wr_cnt), 80'(512));
    chk("f2_row1", {cap[1][0], cap[1][1], cap[1][2], cap[1][3]}, {14'd7, 14'd4, 14'd5, 14'd6});

    // Frame 3: reduction corner values, ntt_busy stall over row 37, start while busy.
    wr_cnt = 0; mode = 1;
    pulse_start();
    send(0, 151, 1'b0);
    @(posedge clk); #1;
    ntt_busy = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wr_en", 80'(wr_en), 80'(0));
      chk("stall_in_ready", 80'(in_ready), 80'(0));
      @(posedge clk); #1;
      start = 1'b0;
    end
    ntt_busy = 1'b0;
    @(negedge clk);
    chk("stall_release_row", {wr_en, wr_row, busy}, {1'b1, 9'd37, 1'b1});
    @(posedge clk); #1;
    send(152, TN - 1, 1'b0);
    wait_done();
    chk("f3_wr_count", 80'(wr_cnt), 80'(512));
    chk("red_row25", {cap[25][0], cap[25][1], cap[25][2], cap[25][3]},
        {14'd4090, 14'd0, 14'd12288, 14'd0});
    chk("red_row26_bank1", 80'(cap[26][1]), 80'(0));

    // Frame 4: reset mid-frame after 1001 coefficients.
    mode = 2;
    pulse_start();
    send(0, 1000, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_ctrl", {wr_en, in_ready, busy, done, wr_row}, '0);
    chk("midrst_data", {wr_data0, wr_data1, wr_data2, wr_data3}, '0);
    exp_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    wr_cnt = 0; first_row = -1;

    // Frame 5: fresh frame after reset.
    pulse_start();
    send(0, TN - 1, 1'b1);
    wait_done();
    chk("f5_first_row", 80'(first_row), 80'(0));
    chk("f5_wr_count", 80'(wr_cnt), 80'(512));
    chk("f5_queue_empty", 80'(exp_q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_loader.md
Name: ntt_loader

Overview:
- Upstream input stage of the NTT accelerator.
- Accepts a serial valid/ready stream of N raw polynomial coefficients and reduces each one mod q.
- Groups every four consecutive coefficients into one row. Writes that row to the four coefficient banks in a single cycle, using the conflict-free bank mapping the butterfly datapath reads with.
- Pulses done when the last row is written; this pulse is the start for the NTT controller.

Parameters:
- N, 2048, polynomial length; a multiple of 4.
- ROWW, 9, row address width; equals log2(N/4).
- IN_W, 16, raw input coefficient width.
- DW, `datawidth, stored coefficient width; must hold q-1.
- Q, 12289, modulus.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load frame.
- ntt_busy  in  1  NTT core owns the banks; the loader must not write.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data this cycle.
- in_data  in  IN_W  raw coefficient, unsigned.
- wr_en  out  1  four-bank write strobe.
- wr_row  out  ROWW  row address shared by all four banks.
- wr_data0..wr_data3  out  DW each  data for bank 0..3.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the final row is written.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, buffers cleared.
  - Reset is asynchronous and may assert mid-frame: abort immediately, no partial write, no done.
- States:
  - IDLE: start && !ntt_busy -> LOAD, busy=1. A start that arrives while busy or while ntt_busy=1 is ignored.
  - LOAD: the coefficient counter cnt (log2(N)+1 bits) counts handshakes (in_valid && in_ready).
    - in_ready = (state==LOAD) && (cnt<N) && !stall.
    - When cnt reaches N -> FLUSH.
  - FLUSH: wait for the pipeline to drain and the last write to issue -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Stage 1, reduction (registered):
  - r = in_data mod Q, computed by a comparison ladder against k*Q for k=1..5. IN_W=16 gives a maximum quotient of 5.
  - Result is in [0, Q-1].
- Stage 2, collect:
  - The reduced value for coefficient n goes to lane j=n[1:0] of a 4-entry buffer.
  - When lane 3 fills, row r = n>>2 is complete.
- Write:
  - wr_en is asserted for exactly one cycle for each complete row.
  - wr_row = r.
  - s = (sum of the 2-bit digits of r) mod 4.
  - Bank b receives coefficient 4r + ((b - s) mod 4).
  - The four coefficients of a row always land in distinct banks.
- Latency: the handshake of coefficient 4r+3 at cycle t gives wr_en at cycle t+2.
  - done asserts the cycle after the write of row N/4-1.
- Stall:
  - stall = ntt_busy, or a complete row is pending and not yet written.
  - While ntt_busy=1, wr_en stays 0, the pending row and pipeline registers hold, and in_ready=0.
  - Writing resumes on the first cycle with ntt_busy=0.
- Handshake:
  - in_data is sampled only on a handshake.
  - in_valid while IDLE/FLUSH/DONE is ignored. No coefficient is ever dropped or duplicated.
- Row sequence: wr_row increments 0..N/4-1 and never wraps within a frame. A new frame restarts at row 0.
- Simultaneous events: start during DONE is ignored; it is accepted only in IDLE.

Decomposition:
- Shared package ntt_pkg holds:
  - constants Q, N, ROWW, IN_W;
  - function bank_sel(row), the digit-sum mod 4, shared with the address mapping used by the NTT core.
- One sub-module: mod_reduce_q, the single-stage registered IN_W->DW reduction. It has a stall hold input.

Test Plan:
1. Reset, start, then stream n=0..2047 with in_valid constant -> 512 writes.
   - Row 1 (s=1): bank0=7, bank1=4, bank2=5, bank3=6.
   - Row 0: bank b = b.
   - done arrives 1 cycle after row 511.
2. Reduction: in_data 65535 -> 4090; 12289 -> 0; 12288 -> 12288; 24578 -> 0; 0 -> 0, each checked at its mapped bank.
3. Random in_valid gaps at 50% duty -> write order and contents identical to scenario 1; exactly 512 wr_en pulses.
4. ntt_busy raised for 10 cycles mid-frame, with row 37 pending -> wr_en=0 and in_ready=0 for 10 cycles. Row 37 is then written unchanged; no coefficient is lost.
5. Start pulsed while busy, and start pulsed with ntt_busy=1 in IDLE -> both ignored; busy and counter are unaffected.
6. rstn dropped after 1001 coefficients -> outputs 0 immediately. A new frame after reset begins at wr_row 0 with no stale data.
